// File: rtl/note_player_harmonic.sv
`default_nettype none
// ============================================================================
//  Module   : note_player_harmonic
//  Purpose  : Harmonic note synthesizer. Latches a note number and runs a
//             22-bit phase accumulator at the note's pitch. On each codec
//             request it returns the fundamental sine plus 2nd/3rd harmonics,
//             mixed according to a 2-bit weight.
//             Pipeline: request -> table reads (stage 1) -> mix (stage 2).
//             The result appears two cycles after the request.
//  Ports    :
//    clk                   in   1   system clock, rising edge
//    reset                 in   1   synchronous, active-low reset
//    play_enable           in   1   1: phase advances on requests, 0: paused
//    note_to_load          in   6   0 = rest, 1..63 semitones (49 = A4)
//    load_new_note         in   1   latch note_to_load and clear phase
//    weight                in   2   harmonic mix select
//    generate_next_sample  in   1   one sample request per high cycle
//    harmonic_out          out 18   signed sample, held between strobes
//    harmonic_ready        out  1   one-cycle strobe, harmonic_out valid
//  Revision : 1.0  initial release
// ============================================================================
module note_player_harmonic (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic [5:0]  note_to_load,
  input  logic        load_new_note,
  input  logic [1:0]  weight,
  input  logic        generate_next_sample,
  output logic [17:0] harmonic_out,
  output logic        harmonic_ready
);

  localparam real PI = 3.14159265358979323846;

  // Table contents are pure functions of the index, so the ROMs below fold
  // to constants: round(32767*sin(2*pi*i/1024)).
  function automatic logic signed [15:0] sine_entry(input int idx);
    real v;
    v = 32767.0 * $sin(2.0 * PI * real'(idx) / 1024.0);
    if (v >= 0.0) return 16'($rtoi(v + 0.5));
    else          return 16'(-$rtoi(0.5 - v));
  endfunction

  // Phase increment for a note at 48 kHz with a 22-bit accumulator.
  function automatic logic [21:0] step_entry(input int n);
    real v;
    if (n == 0) return '0;
    v = 440.0 * $pow(2.0, real'(n - 49) / 12.0) * 4194304.0 / 48000.0;
    return 22'($rtoi(v + 0.5));
  endfunction

  logic signed [15:0] sine_rom [1024];
  logic        [21:0] step_rom [64];

  for (genvar i = 0; i < 1024; i++) begin : g_sine
    assign sine_rom[i] = sine_entry(i);
  end

  for (genvar n = 0; n < 64; n++) begin : g_step
    assign step_rom[n] = step_entry(n);
  end

  // State
  logic        [5:0]  note_q,   note_d;
  logic        [21:0] phase_q,  phase_d;
  logic signed [15:0] s1_q,     s1_d;
  logic signed [15:0] s2_q,     s2_d;
  logic signed [15:0] s3_q,     s3_d;
  logic               valid1_q, valid1_d;
  logic signed [17:0] out_q,    out_d;
  logic               ready_q,  ready_d;

  // Combinational helpers
  logic        [5:0]  note_eff;
  logic        [21:0] phase_eff;
  logic        [9:0]  addr1, addr2, addr3;
  logic               active;
  logic signed [17:0] e1, e2, e3, mix;

  always_comb begin
    // A load in the same cycle as a request wins: that request already
    // sees phase 0 and the new note.
    note_eff  = load_new_note ? note_to_load : note_q;
    phase_eff = load_new_note ? 22'd0 : phase_q;

    // Harmonic addresses are the top 10 bits of p, 2p and 3p (mod 2^22).
    addr1 = phase_eff[21:12];
    addr2 = phase_eff[20:11];
    addr3 = 10'((phase_eff + {phase_eff[20:0], 1'b0}) >> 12);

    active = generate_next_sample & play_enable;

    note_d  = note_eff;
    phase_d = phase_eff;
    if (active) phase_d = phase_eff + step_rom[note_eff];

    // Paused requests still travel down the pipe, but carry silence.
    valid1_d = generate_next_sample;
    s1_d     = active ? sine_rom[addr1] : 16'sd0;
    s2_d     = active ? sine_rom[addr2] : 16'sd0;
    s3_d     = active ? sine_rom[addr3] : 16'sd0;

    e1 = {{2{s1_q[15]}}, s1_q};
    e2 = {{2{s2_q[15]}}, s2_q};
    e3 = {{2{s3_q[15]}}, s3_q};

    mix = e1;
    case (weight)
      2'd0:    mix = e1;
      2'd1:    mix = e1 + (e2 >>> 1);
      2'd2:    mix = e1 + (e2 >>> 1) + (e3 >>> 2);
      default: mix = e1 + e2 + e3;
    endcase

    out_d   = valid1_q ? mix : out_q;
    ready_d = valid1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      note_q   <= '0;
      phase_q  <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      valid1_q <= 1'b0;
      out_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      note_q   <= note_d;
      phase_q  <= phase_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      valid1_q <= valid1_d;
      out_q    <= out_d;
      ready_q  <= ready_d;
    end
  end

  assign harmonic_out   = out_q;
  assign harmonic_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_note_player_harmonic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_note_player_harmonic
//  Purpose  : Self-checking bench for note_player_harmonic. A reference model
//             of phase/note/mix pushes expected samples with their due cycle
//             into a scoreboard; a negedge monitor compares DUT strobes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_player_harmonic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play_enable = 1'b0;
  logic [5:0]  note_to_load = '0;
  logic        load_new_note = 1'b0;
  logic [1:0]  weight = '0;
  logic        generate_next_sample = 1'b0;
  logic [17:0] harmonic_out;
  logic        harmonic_ready;

  always #5 clk = ~clk;

  note_player_harmonic dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .load_new_note        (load_new_note),
    .weight               (weight),
    .generate_next_sample (generate_next_sample),
    .harmonic_out         (harmonic_out),
    .harmonic_ready       (harmonic_ready)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   sine_tab[1024];
  int   step_tab[64];
  int   m_phase = 0;
  int   m_note  = 0;
  int   last_out = 0;
  bit   mon_on = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  bit   mon_exp_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int round_r(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic int mix_ref(input int p);
    int a1, a2, a3, s1, s2, s3;
    a1 = (p >> 12) & 1023;
    a2 = ((2 * p) & 32'h3FFFFF) >> 12;
    a3 = ((3 * p) & 32'h3FFFFF) >> 12;
    s1 = sine_tab[a1];
    s2 = sine_tab[a2];
    s3 = sine_tab[a3];
    case (weight)
      2'd0:    return s1;
      2'd1:    return s1 + (s2 >>> 1);
      2'd2:    return s1 + (s2 >>> 1) + (s3 >>> 2);
      default: return s1 + s2 + s3;
    endcase
  endfunction

  // Drive one cycle of stimulus (called at posedge+1) and update the model.
  task automatic drive(input bit req, input bit ld, input int note, input bit en);
    int   pe, ne;
    exp_t e;
    generate_next_sample = req;
    load_new_note        = ld;
    note_to_load         = 6'(note);
    play_enable          = en;
    pe = ld ? 0 : m_phase;
    ne = ld ? note : m_note;
    if (req) begin
      e.val = en ? mix_ref(pe) : 0;
      e.due = cyc + 2;
      sb.push_back(e);
      if (en) pe = (pe + step_tab[ne]) & 32'h3FFFFF;
    end
    m_phase = pe;
    m_note  = ne;
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 1'b1);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic apply_reset(input int n);
    mon_on = 1'b0;
    reset  = 1'b0;
    generate_next_sample = 1'b0;
    load_new_note = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("reset_out", $signed(harmonic_out), 0);
    check("reset_ready", harmonic_ready, 0);
    sb.delete();
    m_phase  = 0;
    m_note   = 0;
    last_out = 0;
    reset    = 1'b1;
    mon_on   = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_exp_rdy = (sb.size() > 0) && (sb[0].due == cyc);
      check("ready", harmonic_ready, mon_exp_rdy);
      if (mon_exp_rdy) begin
        mon_e = sb.pop_front();
        check("sample", $signed(harmonic_out), mon_e.val);
        last_out = mon_e.val;
      end else begin
        check("hold", $signed(harmonic_out), last_out);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      sine_tab[i] = round_r(32767.0 * $sin(2.0 * 3.14159265358979323846 * i / 1024.0));
    step_tab[0] = 0;
    for (int n = 1; n < 64; n++)
      step_tab[n] = round_r(440.0 * $pow(2.0, (n - 49) / 12.0) * 4194304.0 / 48000.0);

    // Reset, then idle with no requests: outputs must stay 0.
    @(posedge clk);
    #1;
    apply_reset(2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 1'b1);

    // Note 1, weight 0, continuous requests; then reload note 22 mid-play.
    weight = 2'd0;
    drive(1'b1, 1'b1, 1, 1'b1);
    run_req(1000);
    drive(1'b1, 1'b1, 22, 1'b1);
    run_req(200);
    drain();

    // Weight sweep through the point where a1 = 256 (request 437 of note 1).
    for (int w = 0; w < 4; w++) begin
      weight = 2'(w);
      drive(1'b1, 1'b1, 1, 1'b1);
      run_req(439);
      drain();
    end

    // Pause: strobes continue with zero output, phase frozen; then resume
    // with random request gaps.
    weight = 2'd2;
    drive(1'b1, 1'b1, 40, 1'b1);
    run_req(30);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 60; i++) drive(1'($urandom_range(0, 1)), 1'b0, 0, 1'b1);
    drain();

    // Load without a coincident request, then play.
    weight = 2'd1;
    drive(1'b0, 1'b1, 10, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b1);
    run_req(25);
    drain();

    // Rest note, then note 63 long enough to wrap the phase many times.
    weight = 2'd3;
    drive(1'b1, 1'b1, 0, 1'b1);
    run_req(30);
    drive(1'b1, 1'b1, 63, 1'b1);
    run_req(200);
    drain();

    // Reset while samples are in flight: they must be discarded.
    weight = 2'd0;
    drive(1'b1, 1'b1, 49, 1'b1);
    run_req(5);
    apply_reset(2);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b1, 49, 1'b1);
    run_req(10);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
